// File: rtl/fifo_wr_arbiter_if.sv
// Requester-to-FIFO write bus for fifo_wr_arbiter: requester handshakes,
// the FIFO write port and the arbiter status outputs.
`timescale 1ns/1ps
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_wfull;
    logic                  fifo_winc;
    logic [WIDTH-1:0]      fifo_wdata;
    logic [IW-1:0]         gnt_id;
    logic                  locked;
    logic [15:0]           wr_count;

    modport slave (
        input  req_valid, req_data, fifo_wfull,
        output req_ready, fifo_winc, fifo_wdata, gnt_id, locked, wr_count
    );

    modport master (
        output req_valid, req_data, fifo_wfull,
        input  req_ready, fifo_winc, fifo_wdata, gnt_id, locked, wr_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NREQ requesters onto one FIFO write port with a
// zero-latency data path. Define WR_ARB_BURST_EN to lock grants for up to BURST_LEN beats.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_rr_ptr, w_rr_nxt;
    logic [IW-1:0]   r_gnt_id, w_gnt_nxt;
    logic [7:0]      r_beat_cnt, w_beat_nxt;
    logic [15:0]     r_wr_count, w_wr_nxt;
    logic [IW-1:0]   w_winner, w_sel;
    logic            w_found, w_xfer;
    logic [NREQ-1:0] w_ready;

    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] idx);
        return (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
    endfunction

    // First valid requester at or after r_rr_ptr, wrapping around.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(r_rr_ptr) + i) % NREQ;
            if (!w_found && bus.req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = IW'(idx);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        w_sel   = (r_state == LOCK) ? r_gnt_id : w_winner;
        if (rst_n && !bus.fifo_wfull) begin
            if (r_state == LOCK)
                w_ready[r_gnt_id] = 1'b1;
            else if (w_found)
                w_ready[w_winner] = 1'b1;
        end
    end

    assign w_xfer         = |(bus.req_valid & w_ready);
    assign bus.req_ready  = w_ready;
    assign bus.fifo_winc  = w_xfer;
    assign bus.fifo_wdata = w_xfer ? bus.req_data[int'(w_sel)*WIDTH +: WIDTH] : '0;
    assign bus.gnt_id     = r_gnt_id;
    assign bus.wr_count   = r_wr_count;
`ifdef WR_ARB_BURST_EN
    assign bus.locked     = (r_state == LOCK);
`else
    assign bus.locked     = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_gnt_nxt   = r_gnt_id;
        w_beat_nxt  = r_beat_cnt;
        w_wr_nxt    = r_wr_count;
        if (w_xfer && r_wr_count != 16'hFFFF)
            w_wr_nxt = r_wr_count + 16'd1;
        // A full FIFO freezes all arbitration state.
        if (!bus.fifo_wfull) begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        w_gnt_nxt = w_winner;
`ifdef WR_ARB_BURST_EN
                        if (BURST_LEN == 1) begin
                            w_rr_nxt = f_next(w_winner);
                        end else begin
                            w_state_nxt = LOCK;
                            w_beat_nxt  = 8'd1;
                        end
`else
                        w_rr_nxt = f_next(w_winner);
`endif
                    end
                end
                LOCK: begin
                    if (!bus.req_valid[r_gnt_id] ||
                        ({1'b0, r_beat_cnt} + 9'd1 == 9'(BURST_LEN))) begin
                        w_state_nxt = IDLE;
                        w_rr_nxt    = f_next(r_gnt_id);
                        w_beat_nxt  = 8'd0;
                    end else begin
                        w_beat_nxt  = r_beat_cnt + 8'd1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_gnt_id   <= '0;
            r_beat_cnt <= 8'd0;
            r_wr_count <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_gnt_id   <= w_gnt_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_wr_count <= w_wr_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed stimulus pushes expected
// writes, a negedge monitor pops and compares them against the FIFO port.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int BL    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST_LEN(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [WIDTH-1:0] dat(input int i);
        return WIDTH'(8'hA0 + 8'h11 * i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input int id);
        exp_t e;
        e.id   = id;
        e.data = dat(id);
        q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        int   gid;
        exp_t e;
        if (!rst_n) begin
            check("ready_in_reset", 32'(bus.req_ready), 0);
            check("winc_in_reset", 32'(bus.fifo_winc), 0);
        end else begin
            check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
            if (bus.fifo_wfull) check("ready_while_full", 32'(bus.req_ready), 0);
            if (bus.fifo_winc) begin
                gid = -1;
                for (int i = 0; i < NREQ; i++)
                    if (bus.req_valid[i] && bus.req_ready[i]) gid = i;
                check("write_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("write_id", gid, e.id);
                    check("write_data", 32'(bus.fifo_wdata), 32'(e.data));
                end
            end else begin
                check("wdata_zero_idle", 32'(bus.fifo_wdata), 0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus.req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt_id", 32'(bus.gnt_id), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_wr_count", 32'(bus.wr_count), 0);
        bus.req_valid = '0;
        rst_n         = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid  = '0;
        bus.fifo_wfull = 1'b0;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = dat(i);

`ifndef WR_ARB_BURST_EN
        // Round robin with everyone requesting.
        do_reset();
        for (int k = 0; k < 5; k++) push(k % NREQ);
        bus.req_valid = '1;
        repeat (5) @(posedge clk);
        #1;
        bus.req_valid = '0;
        check("rr_wr_count", 32'(bus.wr_count), 5);
        check("rr_gnt_id", 32'(bus.gnt_id), 0);
        check("rr_locked", 32'(bus.locked), 0);

        // Full stalls everything, then arbitration resumes from index 0.
        do_reset();
        bus.fifo_wfull = 1'b1;
        bus.req_valid  = 4'b0101;
        repeat (3) @(posedge clk);
        #1;
        check("full_wr_count", 32'(bus.wr_count), 0);
        check("full_gnt_id", 32'(bus.gnt_id), 0);
        push(0);
        push(2);
        bus.fifo_wfull = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '0;
        check("full_after_wr_count", 32'(bus.wr_count), 2);
        check("full_after_gnt_id", 32'(bus.gnt_id), 2);
`else
        // Two requesters, each locked for a full burst.
        do_reset();
        for (int k = 0; k < BL; k++) push(0);
        for (int k = 0; k < BL; k++) push(1);
        bus.req_valid = 4'b0011;
        @(posedge clk);
        #1;
        check("burst_locked", 32'(bus.locked), 1);
        check("burst_gnt0", 32'(bus.gnt_id), 0);
        repeat (2*BL - 1) @(posedge clk);
        #1;
        bus.req_valid = '0;
        check("burst_unlocked", 32'(bus.locked), 0);
        check("burst_gnt1", 32'(bus.gnt_id), 1);
        check("burst_wr_count", 32'(bus.wr_count), 2*BL);

        // Requester 2 drops valid after two beats; lock passes to 3.
        do_reset();
        bus.req_valid = 4'b0100;
        push(2);
        @(posedge clk);
        #1;
        bus.req_valid = 4'b1100;
        push(2);
        @(posedge clk);
        #1;
        bus.req_valid = 4'b1000;
        check("drop_ready", 32'(bus.req_ready), 32'h4);
        check("drop_winc", 32'(bus.fifo_winc), 0);
        @(posedge clk);
        #1;
        check("drop_released", 32'(bus.locked), 0);
        push(3);
        @(posedge clk);
        #1;
        check("drop_gnt3", 32'(bus.gnt_id), 3);
        check("drop_locked3", 32'(bus.locked), 1);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        check("drop_wr_count", 32'(bus.wr_count), 3);

        // Same drop with 3 idle: next grant wraps to 0.
        do_reset();
        bus.req_valid = 4'b0100;
        push(2);
        @(posedge clk);
        #1;
        bus.req_valid = 4'b0001;
        @(posedge clk);
        #1;
        push(0);
        @(posedge clk);
        #1;
        check("wrap_gnt0", 32'(bus.gnt_id), 0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;

        // Reset in the middle of a burst.
        do_reset();
        bus.req_valid = 4'b0011;
        push(0);
        push(0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_locked", 32'(bus.locked), 0);
        check("midrst_wr_count", 32'(bus.wr_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(0);
        @(posedge clk);
        #1;
        check("midrst_gnt", 32'(bus.gnt_id), 0);
        check("midrst_count1", 32'(bus.wr_count), 1);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
`endif

        // Counter saturation.
        do_reset();
        bus.req_valid = '1;
        for (int k = 0; k < 65540; k++) begin
`ifdef WR_ARB_BURST_EN
            push((k / BL) % NREQ);
`else
            push(k % NREQ);
`endif
            @(posedge clk);
            #1;
            if (k == 65533) check("sat_fffe", 32'(bus.wr_count), 32'hFFFE);
            if (k == 65534) check("sat_ffff", 32'(bus.wr_count), 32'hFFFF);
        end
        bus.req_valid = '0;
        check("sat_hold", 32'(bus.wr_count), 32'hFFFF);

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ SHALL default to 4 and sets the number of requesters (2..8).
REQ-002 Parameter WIDTH SHALL default to 8 and sets the data width per requester.
REQ-003 Parameter BURST_LEN SHALL default to 4 and sets the maximum beats per locked grant (1..255).
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NREQ  per-requester data-valid.
REQ-007 req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NREQ  per-requester accept, combinational.
REQ-009 fifo_wfull  input  1  async FIFO write-side full flag (already synchronized).
REQ-010 fifo_winc  output  1  FIFO write strobe, combinational.
REQ-011 fifo_wdata  output  WIDTH  FIFO write data, combinational.
REQ-012 gnt_id  output  clog2(NREQ)  registered index of the last granted requester.
REQ-013 locked  output  1  registered; high while in LOCK state.
REQ-014 wr_count  output  16  registered count of FIFO writes.

Function
REQ-015 A transfer SHALL occur on requester i in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-016 At most one req_ready bit SHALL be high in any cycle.
REQ-017 fifo_winc SHALL equal OR of (req_valid & req_ready); fifo_wdata SHALL be the winner's req_data, and SHALL be 0 when fifo_winc is low.
REQ-018 While fifo_wfull is high, req_ready SHALL be all zero and no arbitration state SHALL change.
REQ-019 FSM states: IDLE, LOCK.
REQ-020 IDLE: winner SHALL be the first index with req_valid high, searching circularly from rr_ptr; req_ready[winner] = !fifo_wfull.
REQ-021 IDLE, transfer on winner w: gnt_id SHALL load w.
REQ-022 LOCK: req_ready SHALL be asserted only to gnt_id (when !fifo_wfull); other requesters SHALL stall.
REQ-023 LOCK SHALL exit to IDLE with rr_ptr = (gnt_id+1) mod NREQ when beat_cnt reaches BURST_LEN, or when req_valid[gnt_id] is low in a non-full cycle.
REQ-024 Full cycles in LOCK SHALL neither count beats nor release the lock.
REQ-025 wr_count SHALL increment on every transfer and saturate at 0xFFFF.
REQ-026 Zero-latency path: data presented with valid in cycle t SHALL appear on fifo_wdata in cycle t.
REQ-027 A requester SHALL be permitted to drop req_valid without a transfer; no data SHALL be written for it.

Reset
REQ-028 On rst_n low: state IDLE, rr_ptr 0, beat_cnt 0, gnt_id 0, locked 0, wr_count 0.
REQ-029 Reset mid-burst SHALL abort the lock immediately; req_ready and fifo_winc SHALL be 0 while rst_n is low.
REQ-030 After rst_n rises, first arbitration SHALL start from index 0.

Configuration
REQ-031 Macro WR_ARB_BURST_EN defined: IDLE transfer on w SHALL enter LOCK with beat_cnt = 1 (returning to IDLE immediately if BURST_LEN = 1); LOCK transfers increment beat_cnt.
REQ-032 Macro WR_ARB_BURST_EN undefined: LOCK SHALL be unreachable, locked tied 0, and every transfer SHALL set rr_ptr = (w+1) mod NREQ.

Verification
REQ-033 Reset, all req_valid=4'b1111, wfull=0, macro off -> grants 0,1,2,3,0 on consecutive cycles; wr_count=5.
REQ-034 req_valid=4'b0101, wfull high 3 cycles then low -> no winc while full; first grant 0, then 2; rr_ptr unchanged during full.
REQ-035 Macro on, BURST_LEN=4, req_valid=4'b0011 -> 4 beats from req 0 (locked=1), then 4 from req 1; gnt_id 0 then 1.
REQ-036 Macro on, req 2 drops valid after 2 beats -> lock releases, next grant goes to req 3 if valid, else wraps to 0.
REQ-037 Macro on, rst_n pulsed low mid-burst -> locked=0, wr_count=0, next grant to req 0.
REQ-038 Force 65,540 transfers -> wr_count holds 0xFFFF.
